// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the FIFO read-side stream engine.
// Optional feature macro: FIFO_RD_CNT_EN (accepted-word counter on the top level).
package fifo_rd_stream_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 32;
  localparam int RD_BUF_DEPTH   = 2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // True when another read can be issued without overrunning the output buffer.
  function automatic logic rd_room(buf_state_e st, logic inflight, logic pop);
    logic [2:0] occ;
    occ = 3'(st) + 3'(inflight) - 3'(pop);
    return occ < 3'(RD_BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Two-entry ring buffer holding words returned by the FIFO until the stream
// consumer accepts them; head_data is a registered storage output.
module fifo_rd_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output buf_state_e            state
);

  logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RD_BUF_DEPTH];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  buf_state_e            state_q, state_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    // NOTE: combinational logic uses blocking '=', the flops below use non-blocking '<='.
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;

    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end

    unique case ({push, pop})
      2'b10:   state_d = (state_q == BUF_EMPTY) ? BUF_ONE : BUF_TWO;
      2'b01:   state_d = (state_q == BUF_TWO) ? BUF_ONE : BUF_EMPTY;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: storage is reset as well, so m_data reads 0 after reset instead of stale words.
      for (int i = 0; i < RD_BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      state_q <= BUF_EMPTY;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      state_q <= state_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign state     = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains fifo_sync through a 2-entry buffer onto a valid/ready stream at 1 word/cycle.
// Optional feature macro: FIFO_RD_CNT_EN adds the word_cnt accepted-word counter.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef FIFO_RD_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_CNT_EN
  , output logic [CNT_WIDTH-1:0] word_cnt
`endif
);

  buf_state_e buf_state;
  logic       inflight_q, inflight_d;
  logic       pop;

  assign m_valid = (buf_state != BUF_EMPTY);
  assign pop     = m_valid && m_ready;

  // Reads are gated by reset_n so the FIFO is never popped while this block is held in reset.
  always_comb begin
    fifo_rd_en = reset_n && !fifo_empty && rd_room(buf_state, inflight_q, pop);
    inflight_d = fifo_rd_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight_q <= 1'b0;
    else          inflight_q <= inflight_d;
  end

  fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (m_data),
    .state     (buf_state)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (pop) word_cnt_d = word_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) word_cnt_q <= '0;
    else          word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
